// File: rtl/simple_mips_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// simple_mips_dmem_responder_if
// Load/store channel between the simple_mips load/store stage (master) and
// the data-memory responder (slave). Request and response are independent
// valid/ready handshakes; only one request is ever outstanding.
//
// Signals:
//   req_valid   master -> slave   request present
//   req_ready   slave  -> master  responder can accept a request
//   req_we      master -> slave   1 = store, 0 = load
//   req_size    master -> slave   0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_signed  master -> slave   sign-extend byte/half loads
//   req_addr    master -> slave   byte address
//   req_wdata   master -> slave   store data, right-justified
//   rsp_valid   slave  -> master  response present
//   rsp_ready   master -> slave   initiator accepts the response
//   rsp_rdata   slave  -> master  extended load data, 0 for stores/errors
//   rsp_err     slave  -> master  misaligned access or illegal size
// ---------------------------------------------------------------------------
interface simple_mips_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/simple_mips_dmem_responder.sv
// ---------------------------------------------------------------------------
// simple_mips_dmem_responder
// Data-memory responder for the simple_mips core. Accepts one load/store at a
// time, waits a fixed LATENCY cycles, then performs a byte/half/word access on
// a little-endian array of 2**ADDR_WIDTH 32-bit words and returns read data or
// a store acknowledge. Misaligned accesses and size 3 return rsp_err=1 with no
// array write. Array contents are not reset and start undefined.
//
// Parameters:
//   ADDR_WIDTH  word-index bits (upper byte-address bits alias)
//   LATENCY     cycles from request accept to rsp_valid, 1..15
//
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    slave side of simple_mips_dmem_responder_if
// ---------------------------------------------------------------------------
module simple_mips_dmem_responder #(
    parameter int ADDR_WIDTH = 18,
    parameter int LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    simple_mips_dmem_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

    state_t state, state_next;
    logic [3:0] count, count_next;

    logic                  lat_we;
    logic [1:0]            lat_size;
    logic                  lat_signed;
    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [31:0]           lat_wdata;

    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    logic accept, finish_access, rsp_done;

    logic [ADDR_WIDTH-1:0] word_index;
    logic [1:0]            lane;
    logic                  access_err;
    logic [31:0]           cur_word;
    logic [31:0]           shifted_word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_data;
    logic [3:0]            byte_en;
    logic [31:0]           store_data;
    logic                  mem_we;

    // Upper address bits deliberately alias onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH+2];

    // Next-state logic. The access itself happens on the edge that leaves
    // BUSY, so a reset that lands while still in BUSY drops the access.
    always_comb begin
        state_next    = state;
        count_next    = count;
        accept        = 1'b0;
        finish_access = 1'b0;
        rsp_done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                    count_next = 4'd0;
                end
            end
            BUSY: begin
                if (count == LAST_COUNT) begin
                    finish_access = 1'b1;
                    state_next    = RESP;
                end else begin
                    count_next = count + 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decode of the latched request: alignment, load extraction and store
    // byte enables. Stores shift wdata into the addressed lane(s).
    always_comb begin
        word_index   = lat_addr[ADDR_WIDTH+1:2];
        lane         = lat_addr[1:0];
        cur_word     = mem[word_index];
        shifted_word = cur_word >> {lane, 3'b000};
        byte_sel     = shifted_word[7:0];
        half_sel     = lat_addr[1] ? cur_word[31:16] : cur_word[15:0];
        store_data   = lat_wdata << {lane, 3'b000};
        access_err   = 1'b0;
        load_data    = 32'd0;
        byte_en      = 4'b0000;
        case (lat_size)
            2'd0: begin
                load_data = lat_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
                byte_en   = 4'b0001 << lane;
            end
            2'd1: begin
                access_err = lat_addr[0];
                load_data  = lat_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
                byte_en    = lat_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                access_err = (lane != 2'd0);
                load_data  = cur_word;
                byte_en    = 4'b1111;
            end
            default: access_err = 1'b1;
        endcase
        mem_we = finish_access & lat_we & ~access_err;
    end

    // Array write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && byte_en[i]) begin
                mem[word_index][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

    // State, request latch and response registers. The response is held
    // stable in RESP and cleared on the handshake edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 4'd0;
            lat_we      <= 1'b0;
            lat_size    <= 2'd0;
            lat_signed  <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                lat_we     <= bus.req_we;
                lat_size   <= bus.req_size;
                lat_signed <= bus.req_signed;
                lat_addr   <= bus.req_addr[ADDR_WIDTH+1:0];
                lat_wdata  <= bus.req_wdata;
            end
            if (finish_access) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= access_err;
                rsp_rdata_q <= (lat_we || access_err) ? 32'd0 : load_data;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= 32'd0;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_simple_mips_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_simple_mips_dmem_responder
// Directed bench for simple_mips_dmem_responder with LATENCY=2. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_simple_mips_dmem_responder;

    localparam int LAT = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] rd;
    logic        er;
    int          lat;

    simple_mips_dmem_responder_if bus ();

    simple_mips_dmem_responder #(
        .ADDR_WIDTH (18),
        .LATENCY    (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for rsp_valid; n counts falling edges waited.
    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("rsp_timeout", 32'(n < 50), 32'd1);
    endtask

    // One full transaction with rsp_ready held high. Request fields are
    // scrambled after acceptance to show they are ignored outside IDLE.
    task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err, output int n);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.rsp_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_size   = ~size;
        bus.req_signed = ~sgn;
        bus.req_addr   = ~addr;
        bus.req_wdata  = ~wdata;
        wait_rsp(n);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(posedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b1;

        // Test 1: reset clears outputs before the first clock edge
        #3 reset = 1'b1;
        #1;
        check_output("rst_async_req_ready", 32'(bus.req_ready), 32'd1);
        check_output("rst_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("rst_async_rsp_rdata", bus.rsp_rdata, 32'd0);
        check_output("rst_async_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        $display("[TB] reset checks done");

        // Test 2: word store then word load, latency measured
        apply_stimulus(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, rd, er, lat);
        check_output("sw_ack_rdata", rd, 32'd0);
        check_output("sw_ack_err", 32'(er), 32'd0);
        check_output("sw_latency", 32'(lat), 32'(LAT));
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, rd, er, lat);
        check_output("lw_100", rd, 32'hDEADBEEF);
        check_output("lw_100_err", 32'(er), 32'd0);
        check_output("lw_latency", 32'(lat), 32'(LAT));

        // Test 3: byte store into lane 3, sub-word loads
        apply_stimulus(1'b1, 2'd0, 1'b0, 32'h103, 32'h12345680, rd, er, lat);
        check_output("sb_ack_err", 32'(er), 32'd0);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, rd, er, lat);
        check_output("lw_after_sb", rd, 32'h80ADBEEF);
        apply_stimulus(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, rd, er, lat);
        check_output("lb_103", rd, 32'hFFFFFF80);
        apply_stimulus(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, rd, er, lat);
        check_output("lbu_103", rd, 32'h00000080);
        apply_stimulus(1'b0, 2'd1, 1'b1, 32'h102, 32'd0, rd, er, lat);
        check_output("lh_102", rd, 32'hFFFF80AD);
        apply_stimulus(1'b0, 2'd1, 1'b0, 32'h100, 32'd0, rd, er, lat);
        check_output("lhu_100", rd, 32'h0000BEEF);
        apply_stimulus(1'b0, 2'd1, 1'b1, 32'h100, 32'd0, rd, er, lat);
        check_output("lh_100", rd, 32'hFFFFBEEF);
        apply_stimulus(1'b0, 2'd0, 1'b0, 32'h101, 32'd0, rd, er, lat);
        check_output("lbu_101", rd, 32'h000000BE);
        apply_stimulus(1'b0, 2'd2, 1'b1, 32'h100, 32'd0, rd, er, lat);
        check_output("lw_signed_ignored", rd, 32'h80ADBEEF);

        // Test 4: alignment and illegal size errors
        apply_stimulus(1'b0, 2'd1, 1'b1, 32'h101, 32'd0, rd, er, lat);
        check_output("lh_101_err", 32'(er), 32'd1);
        check_output("lh_101_rdata", rd, 32'd0);
        apply_stimulus(1'b1, 2'd2, 1'b0, 32'h102, 32'd0, rd, er, lat);
        check_output("sw_102_err", 32'(er), 32'd1);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, rd, er, lat);
        check_output("lw_after_bad_sw", rd, 32'h80ADBEEF);
        apply_stimulus(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, rd, er, lat);
        check_output("size3_err", 32'(er), 32'd1);
        check_output("size3_rdata", rd, 32'd0);
        apply_stimulus(1'b1, 2'd1, 1'b0, 32'h102, 32'h00005A5A, rd, er, lat);
        check_output("sh_102_err", 32'(er), 32'd0);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, rd, er, lat);
        check_output("lw_after_sh", rd, 32'h5A5ABEEF);

        // Test 5: response back-pressure with a request waiting
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd2;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h100;
        bus.rsp_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_size   = 2'd0;
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("hold_rsp_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
            check_output($sformatf("hold_rsp_rdata_%0d", i), bus.rsp_rdata, 32'h5A5ABEEF);
            check_output($sformatf("hold_req_ready_%0d", i), 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("after_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("after_hs_rsp_rdata", bus.rsp_rdata, 32'd0);
        check_output("after_hs_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_output("held_req_accepted", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        wait_rsp(lat);
        check_output("held_lbu_100", bus.rsp_rdata, 32'h000000EF);
        @(posedge clk);

        // Asynchronous reset while a response is pending
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h101;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(lat);
        check_output("resp_misaligned_err", 32'(bus.rsp_err), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("mid_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_output("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;

        // Test 6: address aliasing, then a store abandoned by reset in BUSY
        apply_stimulus(1'b1, 2'd2, 1'b0, 32'h00100100, 32'hCAFEF00D, rd, er, lat);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, rd, er, lat);
        check_output("lw_alias", rd, 32'hCAFEF00D);
        apply_stimulus(1'b1, 2'd2, 1'b0, 32'h200, 32'h11111111, rd, er, lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h200;
        bus.req_wdata = 32'h00000001;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_output("busy_req_ready", 32'(bus.req_ready), 32'd0);
        #1 reset = 1'b1;
        #1;
        check_output("busy_rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("busy_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h200, 32'd0, rd, er, lat);
        check_output("lw_200_unwritten", rd, 32'h11111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
